time_set_ctrl: RTL
==================

// Module: time_set_ctrl
// PURPOSE
//  Front-panel time/date setting controller; sits upstream of watch_date and drives its set_time/bin_time.
//  Debounces the four raw push-buttons (sw_in) and runs a field-select edit FSM over a shadow copy of the date/time.
//  Commits the edited value to the timekeeper with a one-cycle set_time pulse.
//  Exports edit state (field_sel, blink) so the display list can highlight the field being edited.
// PARAMETERS
//  CLK_HZ       50_000_000  clk frequency in Hz
//  DEBOUNCE_MS  20          input stable time before a level is accepted
//  TIMEOUT_S    30          seconds without a press before the edit is abandoned
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  en_1hz       in   1   one-cycle 1 Hz enable from en_clk
//  sw_in        in   4   raw buttons, active-high: [0]=MODE [1]=NEXT [2]=INC [3]=DEC
//  cur_year     in   8   live year, binary 0..99
//  cur_month    in   8   live month, 1..12
//  cur_day      in   8   live day, 1..31
//  cur_hour     in   8   live hour, 0..23
//  cur_minute   in   8   live minute, 0..59
//  cur_second   in   8   live second, 0..59
//  set_time     out  1   one-cycle commit strobe to watch_date
//  bin_time     out  48  {year,month,day,hour,minute,second}; valid while set_time=1, held otherwise
//  edit_active  out  1   high in every EDIT_* state
//  field_sel    out  3   0=year 1=month 2=day 3=hour 4=min 5=sec; 0 when idle
//  blink        out  1   toggles on en_1hz while editing; 0 when idle
// BEHAVIOUR
//  Reset: set_time=0, edit_active=0, field_sel=0, blink=0, shadow/bin_time={0,1,1,0,0,0}, FSM=IDLE.
//  Debounce per button: 2-flop synchronizer, then a counter that accepts a new level after DEBOUNCE_MS*CLK_HZ/1000 stable cycles.
//  The debounce output rising edge gives a 1-cycle press; total latency from a clean edge = sync(2) + debounce count + 1.
//  FSM states: IDLE, EDIT_YEAR..EDIT_SEC, COMMIT.
//   IDLE + MODE: capture cur_* into shadow, go to EDIT_YEAR, reset timeout.
//   EDIT_x + NEXT: go to the next field; EDIT_SEC wraps to EDIT_YEAR.
//   EDIT_x + MODE: go to COMMIT. COMMIT lasts one cycle with set_time=1 and bin_time=shadow, then IDLE.
//   EDIT_x + INC/DEC: +/-1 with wrap. Ranges: year 0..99, month 1..12, day 1..dim, hour 0..23, min/sec 0..59.
//  dim = 31/30 per month; Feb = 29 when year%4==0, else 28.
//  A month or year edit that makes day > dim clamps day to dim in the same cycle.
//  Priority among same-cycle presses: MODE > NEXT > INC/DEC. INC and DEC together are both ignored.
//  Timeout: counts en_1hz while editing, reset by any press. At TIMEOUT_S go to IDLE without set_time and discard the shadow.
//  rst mid-edit: back to IDLE at once, no set_time, shadow reloaded to the reset value.
//  bin_time changes only on COMMIT or reset.
// CONFIGURATION
//  Macro TSC_AUTOREPEAT_EN:
//   defined: INC/DEC held >=500 ms emits a repeat press every 100 ms until release. Repeats also reset the timeout.
//   undefined: exactly one step per press; no repeat counters are synthesized.
// STRUCTURE
//  Package time_set_pkg holds:
//   field encoding constants, range min/max constants, the bin_time packing order, and function days_in_month(month, year).
//  Sub-module sw_debounce (sync + stability counter + edge pulse), instantiated 4x with parameters CLK_HZ and DEBOUNCE_MS.
// TESTING
//  (bench overrides CLK_HZ=1000, DEBOUNCE_MS=2)
//  1. cur={24,2,28,23,59,58}; MODE, INC on day, MODE -> set_time one cycle, bin_time={24,2,29,23,59,58}.
//  2. Edit year 23, month 2, day 29 -> day clamps to 28. DEC on month at 1 -> month 12.
//  3. INC on hour 23 -> 0; on min 59 -> 0. NEXT from sec -> field_sel 0. INC+DEC same cycle -> no change.
//  4. Glitch pulses shorter than the debounce window on MODE -> no state change. A clean press -> edit_active after the latency above.
//  5. Enter edit, send no presses for TIMEOUT_S en_1hz pulses -> IDLE with set_time never asserted. rst mid-edit -> all outputs at reset values.
//  6. With TSC_AUTOREPEAT_EN, hold INC on minute for 1 s -> 1 + 6 increments. Without the macro -> 1 increment.

Source files
------------

// File: rtl/time_set_pkg.sv
// -----------------------------------------------------------------------------
// time_set_pkg
//   Shared definitions for the front-panel time/date setting controller:
//   button indices, edit-field and FSM state encodings, legal field ranges,
//   the bin_time packing order and the calendar/step helper functions.
// -----------------------------------------------------------------------------
package time_set_pkg;

    // Button bit positions inside sw_in.
    localparam int NUM_BTN  = 4;
    localparam int BTN_MODE = 0;
    localparam int BTN_NEXT = 1;
    localparam int BTN_INC  = 2;
    localparam int BTN_DEC  = 3;

    // Field encoding as exported on field_sel.
    typedef enum logic [2:0] {
        FIELD_YEAR  = 3'd0,
        FIELD_MONTH = 3'd1,
        FIELD_DAY   = 3'd2,
        FIELD_HOUR  = 3'd3,
        FIELD_MIN   = 3'd4,
        FIELD_SEC   = 3'd5
    } field_e;

    // Edit states are laid out so that (state - 1) is the field being edited.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EDIT_YEAR  = 3'd1,
        EDIT_MONTH = 3'd2,
        EDIT_DAY   = 3'd3,
        EDIT_HOUR  = 3'd4,
        EDIT_MIN   = 3'd5,
        EDIT_SEC   = 3'd6,
        COMMIT     = 3'd7
    } state_e;

    // Legal ranges; the day maximum depends on month/year (days_in_month).
    localparam logic [7:0] YEAR_MIN  = 8'd0;
    localparam logic [7:0] YEAR_MAX  = 8'd99;
    localparam logic [7:0] MONTH_MIN = 8'd1;
    localparam logic [7:0] MONTH_MAX = 8'd12;
    localparam logic [7:0] DAY_MIN   = 8'd1;
    localparam logic [7:0] HOUR_MIN  = 8'd0;
    localparam logic [7:0] HOUR_MAX  = 8'd23;
    localparam logic [7:0] MIN_MIN   = 8'd0;
    localparam logic [7:0] MIN_MAX   = 8'd59;
    localparam logic [7:0] SEC_MIN   = 8'd0;
    localparam logic [7:0] SEC_MAX   = 8'd59;

    // Packing order of bin_time: year in the top byte, second in the bottom.
    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } date_time_t;

    localparam int DATE_TIME_W = $bits(date_time_t);

    localparam date_time_t RESET_TIME = '{
        year:   8'd0,
        month:  8'd1,
        day:    8'd1,
        hour:   8'd0,
        minute: 8'd0,
        second: 8'd0
    };

    // Two-digit year: every year divisible by 4 is treated as a leap year.
    function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                 input logic [7:0] year);
        case (month)
            8'd2:                    return ((year % 8'd4) == 8'd0) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
            default:                 return 8'd31;
        endcase
    endfunction

    // One step up or down inside [lo, hi], wrapping at both ends.
    function automatic logic [7:0] wrap_step(input logic [7:0] value,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi,
                                             input logic       up);
        if (up) return (value >= hi) ? lo : value + 8'd1;
        else    return (value <= lo) ? hi : value - 8'd1;
    endfunction

    // Step one field of a date/time, then clamp the day to the length of the
    // (possibly new) month so a month/year edit never leaves an illegal date.
    function automatic date_time_t apply_step(input date_time_t t,
                                              input field_e     field,
                                              input logic       up);
        date_time_t r;
        logic [7:0] dim;
        r = t;
        case (field)
            FIELD_YEAR:  r.year   = wrap_step(t.year,   YEAR_MIN,  YEAR_MAX,  up);
            FIELD_MONTH: r.month  = wrap_step(t.month,  MONTH_MIN, MONTH_MAX, up);
            FIELD_DAY:   r.day    = wrap_step(t.day,    DAY_MIN,
                                              days_in_month(t.month, t.year), up);
            FIELD_HOUR:  r.hour   = wrap_step(t.hour,   HOUR_MIN,  HOUR_MAX,  up);
            FIELD_MIN:   r.minute = wrap_step(t.minute, MIN_MIN,   MIN_MAX,   up);
            FIELD_SEC:   r.second = wrap_step(t.second, SEC_MIN,   SEC_MAX,   up);
            default:     ;
        endcase
        dim = days_in_month(r.month, r.year);
        if (r.day > dim) r.day = dim;
        return r;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   One push-button conditioner: 2-flop synchronizer, stability counter that
//   accepts a new level only after DEBOUNCE_MS*CLK_HZ/1000 consecutive cycles
//   of disagreement, and a rising-edge detector giving a 1-cycle press.
//   Latency from a clean input edge to press = 2 (sync) + debounce count.
//
// Ports
//   clk     in  1  system clock
//   rst     in  1  synchronous, active-high reset
//   sw_raw  in  1  raw, asynchronous, bouncing button (active-high)
//   level   out 1  debounced button level
//   press   out 1  one-cycle pulse on each accepted rising edge of level
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic level,
    output logic press
);

    localparam longint DEB_RAW    = (longint'(DEBOUNCE_MS) * longint'(CLK_HZ)) / 1000;
    localparam int     DEB_CYCLES = (DEB_RAW < 1) ? 1 : int'(DEB_RAW);
    localparam int     CNT_W      = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_ff;
    logic [CNT_W-1:0] stable_cnt;
    logic             level_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others (the synchronizer depends on this).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff    <= 2'b00;
            stable_cnt <= '0;
            level      <= 1'b0;
            level_q    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], sw_raw};
            level_q <= level;
            // Any sample that agrees with the accepted level restarts the count,
            // so a glitch shorter than the window never flips the output.
            if (sync_ff[1] == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_ff[1];
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//   Front-panel time/date setting controller feeding watch_date. Debounces the
//   four buttons, edits a shadow copy of the live date/time field by field and
//   commits it with a one-cycle set_time strobe. Edit state is exported so the
//   display can highlight and blink the selected field.
//
//   Build option: define TSC_AUTOREPEAT_EN to make a held INC/DEC repeat every
//   100 ms after 500 ms. Without it each press is exactly one step.
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   en_1hz       in   1   one-cycle 1 Hz enable
//   sw_in        in   4   raw buttons, active-high: [0]=MODE [1]=NEXT [2]=INC [3]=DEC
//   cur_year     in   8   live year 0..99
//   cur_month    in   8   live month 1..12
//   cur_day      in   8   live day 1..31
//   cur_hour     in   8   live hour 0..23
//   cur_minute   in   8   live minute 0..59
//   cur_second   in   8   live second 0..59
//   set_time     out  1   one-cycle commit strobe
//   bin_time     out  48  {year,month,day,hour,minute,second}, held between commits
//   edit_active  out  1   high while editing a field
//   field_sel    out  3   field being edited (0=year..5=sec), 0 when idle
//   blink        out  1   toggles on en_1hz while editing, 0 when idle
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int TIMEOUT_S   = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_1hz,
    input  logic [3:0]  sw_in,
    input  logic [7:0]  cur_year,
    input  logic [7:0]  cur_month,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_minute,
    input  logic [7:0]  cur_second,
    output logic        set_time,
    output logic [47:0] bin_time,
    output logic        edit_active,
    output logic [2:0]  field_sel,
    output logic        blink
);

    import time_set_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT_S + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

    // ---------------------------------------------------------------- buttons
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic               level_unused;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_debounce
        sw_debounce #(
            .CLK_HZ      (CLK_HZ),
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .sw_raw (sw_in[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i])
        );
    end

    // Button levels only matter to the auto-repeat logic; this sink keeps the
    // default build free of dangling nets.
    assign level_unused = ^btn_level;

    logic mode_press;
    logic next_press;
    logic inc_step;
    logic dec_step;
    logic any_press;

    assign mode_press = btn_press[BTN_MODE];
    assign next_press = btn_press[BTN_NEXT];

`ifdef TSC_AUTOREPEAT_EN
    localparam int RPT_DELAY  = (CLK_HZ / 2 < 2) ? 2 : CLK_HZ / 2;
    localparam int RPT_PERIOD = (CLK_HZ / 10 < 1) ? 1 : CLK_HZ / 10;
    localparam int RPT_W      = $clog2(RPT_DELAY + 1);

    logic             rpt_held;
    logic             rpt_fire;
    logic [RPT_W-1:0] rpt_cnt;

    // Exactly one of INC/DEC held; both held is a no-op anyway.
    assign rpt_held = btn_level[BTN_INC] ^ btn_level[BTN_DEC];
    // The count starts at 0 on the press cycle, so the first repeat lands once
    // the button has been held RPT_DELAY cycles, then every RPT_PERIOD cycles.
    assign rpt_fire = rpt_held && (rpt_cnt == RPT_W'(RPT_DELAY - 1));

    always_ff @(posedge clk) begin
        if (rst || !rpt_held) begin
            rpt_cnt <= '0;
        end else if (rpt_fire) begin
            rpt_cnt <= RPT_W'(RPT_DELAY - RPT_PERIOD);
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end

    assign inc_step = btn_press[BTN_INC] | (rpt_fire & btn_level[BTN_INC]);
    assign dec_step = btn_press[BTN_DEC] | (rpt_fire & btn_level[BTN_DEC]);
`else
    assign inc_step = btn_press[BTN_INC];
    assign dec_step = btn_press[BTN_DEC];
`endif

    // Repeats count as presses so a held button keeps the edit alive.
    assign any_press = mode_press | next_press | inc_step | dec_step;

    // -------------------------------------------------------------- edit FSM
    state_e          state_q,  state_d;
    date_time_t      shadow_q, shadow_d;
    date_time_t      bin_q;
    date_time_t      live_time;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            blink_q,  blink_d;
    logic            load_bin;
    logic            editing;
    field_e          cur_field;

    assign live_time = '{
        year:   cur_year,
        month:  cur_month,
        day:    cur_day,
        hour:   cur_hour,
        minute: cur_minute,
        second: cur_second
    };

    assign editing   = (state_q != IDLE) && (state_q != COMMIT);
    assign cur_field = field_e'(state_q - 3'd1);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        shadow_d = shadow_q;
        to_cnt_d = to_cnt_q;
        blink_d  = blink_q;
        load_bin = 1'b0;

        case (state_q)
            IDLE: begin
                blink_d = 1'b0;
                if (mode_press) begin
                    state_d  = EDIT_YEAR;
                    shadow_d = live_time;
                    to_cnt_d = '0;
                end
            end

            COMMIT: begin
                state_d = IDLE;
                blink_d = 1'b0;
            end

            default: begin
                if (en_1hz) blink_d = ~blink_q;

                // MODE beats NEXT beats INC/DEC; INC+DEC together cancel.
                if (mode_press) begin
                    state_d  = COMMIT;
                    load_bin = 1'b1;
                    blink_d  = 1'b0;
                end else if (next_press) begin
                    state_d = (state_q == EDIT_SEC) ? EDIT_YEAR : state_e'(state_q + 3'd1);
                end else if (inc_step ^ dec_step) begin
                    shadow_d = apply_step(shadow_q, cur_field, inc_step);
                end

                // A press in the same cycle as the final second keeps the edit.
                if (any_press) begin
                    to_cnt_d = '0;
                end else if (en_1hz) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d  = IDLE;
                        shadow_d = RESET_TIME;
                        to_cnt_d = '0;
                        blink_d  = 1'b0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= RESET_TIME;
            bin_q    <= RESET_TIME;
            to_cnt_q <= '0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            to_cnt_q <= to_cnt_d;
            blink_q  <= blink_d;
            // Loaded on entry to COMMIT so bin_time is valid during set_time.
            if (load_bin) bin_q <= shadow_q;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign set_time    = (state_q == COMMIT);
    assign bin_time    = bin_q;
    assign edit_active = editing;
    assign field_sel   = editing ? (state_q - 3'd1) : 3'd0;
    assign blink       = blink_q;

endmodule
